dvi_in_tlul_host: RTL
=====================

// Module: dvi_in_tlul_host
// PURPOSE
//  TL-UL initiator that issues single register accesses to the dvi_in register block (or any TL-UL device).
//  Used by bring-up sequencers and the capture DMA control path when no CPU is present.
//  Converts a simple cmd/rsp valid-ready interface into one TL-UL A-channel request and collects the D-channel response.
//  Detects source mismatch and timeout.
// PARAMETERS
//  AW        32    address width used from cmd_addr (upper bits of a_address tied 0)
//  TimeoutW  16    width of the D-channel timeout counter
//  SrcBase   8'h00 base a_source; the low 2 bits rotate per transaction
// PORTS
//  clk_i        in   1    system clock
//  rst_ni       in   1    async active-low reset
//  cmd_valid_i  in   1    command request
//  cmd_ready_o  out  1    command accepted when valid&ready
//  cmd_write_i  in   1    1=write (PutFullData/PutPartialData), 0=read (Get)
//  cmd_addr_i   in   AW   byte address; bits[1:0] forced 0 on bus
//  cmd_wdata_i  in   32   write data
//  cmd_mask_i   in   4    byte enables; all ones -> PutFullData, otherwise PutPartialData; reads always use mask 4'hF
//  timeout_i    in   TimeoutW  cycles to wait for d_valid; 0 disables the timeout
//  rsp_valid_o  out  1    response available
//  rsp_ready_i  in   1    response consumed when valid&ready
//  rsp_rdata_o  out  32   read data (0 for writes or on error)
//  rsp_err_o    out  1    d_error, source mismatch, or timeout
//  rsp_timeout_o out 1    error caused by the timeout
//  busy_o       out  1    FSM not IDLE
//  tl_o         out  tlul_pkg::tl_h2d_t  request to device
//  tl_i         in   tlul_pkg::tl_d2h_t  response from device
// BEHAVIOUR
//  Reset: FSM=IDLE; cmd_ready_o=1; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; rsp_timeout_o=0; busy_o=0;
//   tl_o.a_valid=0; tl_o.d_ready=0; src_cnt=0; timeout counter=0.
//  FSM IDLE -> A_REQ -> D_WAIT -> RESP -> IDLE; at most one transaction outstanding.
//  IDLE: cmd_ready_o=1. On cmd_valid_i, register the command and go to A_REQ. cmd_ready_o=0 in every other state.
//  A_REQ: a_valid=1 with registered fields held stable.
//   a_size=2; a_param=0; a_source=SrcBase|src_cnt.
//   a_user integrity is generated by tlul_cmd_intg_gen.
//   On a_valid&a_ready: src_cnt++ (2-bit, wraps 3->0), clear the timeout counter, go to D_WAIT.
//   The timeout counter does not run in A_REQ: a stalled a_ready holds indefinitely.
//  D_WAIT: d_ready=1. On d_valid, go to RESP with:
//   rdata = d_data if read and no error, else 0;
//   err = d_error | (d_source != issued source);
//   a wrong d_opcode (AccessAckData expected for reads, AccessAck for writes) also sets err.
//   Timeout counter increments each cycle without d_valid. When it reaches timeout_i (nonzero), go to RESP with err=1, timeout=1, rdata=0.
//   The late D beat is absorbed: after a timeout, d_ready stays 1 and the next d_valid carrying the stale source is dropped.
//   A stale beat never produces a response.
//  RESP: rsp_valid_o=1 with outputs stable. On rsp_ready_i, go to IDLE. Ready may be tied 1, giving a 1-cycle RESP.
//  Latency: cmd accept -> a_valid = 1 cycle; d_valid -> rsp_valid_o = 1 cycle.
//  d_valid arriving in IDLE or A_REQ (not a stale beat) is accepted and discarded, with d_ready=1 in those states.
//  Async reset mid-transaction aborts immediately: a_valid drops and no response is produced.
// TESTING
//  1 Read 0x10, device returns AccessAckData 0xDEADBEEF after 3 cycles -> a_opcode=Get, a_mask=F; rsp_rdata=0xDEADBEEF, err=0.
//  2 Write 0x04 data 0x1, mask 4'h3 -> a_opcode=PutPartialData, a_mask=3; rsp err=0, rdata=0.
//  3 a_ready held low 50 cycles with timeout_i=8 -> no timeout, a_valid stable; then normal completion.
//  4 timeout_i=8, no d_valid -> rsp_err=1, rsp_timeout=1 on cycle 8 of D_WAIT.
//     The late beat for the stale source is dropped; the next cmd completes cleanly.
//  5 d_error=1 on read -> rsp_err=1, rdata=0. Wrong d_source -> rsp_err=1.
//  6 5 back-to-back reads with rsp_ready tied 1 -> a_source cycles 0,1,2,3,0. rst_ni pulsed in D_WAIT -> a_valid=0, rsp_valid=0.

Source files
------------

// File: rtl/dvi_in_tlul_host.sv
// ============================================================================
// Module   : dvi_in_tlul_host
// Brief    : Single-outstanding TL-UL initiator turning cmd/rsp handshakes
//            into one A-channel request and its D-channel response.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tlul_pkg;
    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [7:0]  d_source;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

// Fills a_user integrity with a fold parity of the command and data fields.
module tlul_cmd_intg_gen (
    input  tlul_pkg::tl_h2d_t tl_i,
    output tlul_pkg::tl_h2d_t tl_o
);
    logic [38:0] w_cmd;

    always_comb begin
        tl_o  = tl_i;
        w_cmd = {tl_i.a_opcode, tl_i.a_address, tl_i.a_mask};
        tl_o.a_user.cmd_intg  = '0;
        tl_o.a_user.data_intg = '0;
        for (int i = 0; i < 39; i++) begin
            tl_o.a_user.cmd_intg[3'(i % 7)] = tl_o.a_user.cmd_intg[3'(i % 7)] ^ w_cmd[i];
        end
        for (int i = 0; i < 32; i++) begin
            tl_o.a_user.data_intg[3'(i % 7)] = tl_o.a_user.data_intg[3'(i % 7)] ^ tl_i.a_data[i];
        end
    end
endmodule

module dvi_in_tlul_host #(
    parameter int          AW       = 32,
    parameter int          TimeoutW = 16,
    parameter logic [7:0]  SrcBase  = 8'h00
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [AW-1:0]       cmd_addr_i,
    input  logic [31:0]         cmd_wdata_i,
    input  logic [3:0]          cmd_mask_i,
    input  logic [TimeoutW-1:0] timeout_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [31:0]         rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                rsp_timeout_o,
    output logic                busy_o,
    output tlul_pkg::tl_h2d_t   tl_o,
    input  tlul_pkg::tl_d2h_t   tl_i
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        A_REQ  = 2'd1,
        D_WAIT = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e              r_state, w_state_next;
    logic                r_write;
    logic [AW-1:0]       r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_mask;
    logic [1:0]          r_src_cnt;
    logic [7:0]          r_src;
    logic [TimeoutW-1:0] r_tmo_cnt;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic                r_timeout;
    logic                r_stale_vld;
    logic [7:0]          r_stale_src;
    logic                r_live;

    logic [7:0]          w_a_source;
    logic                w_a_hs;
    logic                w_d_stale;
    logic                w_d_take;
    logic                w_d_err;
    logic                w_tmo_hit;
    logic [2:0]          w_exp_op;
    tlul_pkg::tl_h2d_t   w_tl_raw;

    assign w_a_source = SrcBase | {6'b0, r_src_cnt};
    assign w_a_hs     = (r_state == A_REQ) && tl_i.a_ready;
    // A beat for the request that already timed out is swallowed in any state.
    assign w_d_stale  = tl_i.d_valid && r_stale_vld && (tl_i.d_source == r_stale_src);
    assign w_d_take   = (r_state == D_WAIT) && tl_i.d_valid && !w_d_stale;
    assign w_exp_op   = r_write ? tlul_pkg::AccessAck : tlul_pkg::AccessAckData;
    assign w_d_err    = tl_i.d_error || (tl_i.d_source != r_src) || (tl_i.d_opcode != w_exp_op);
    assign w_tmo_hit  = (r_state == D_WAIT) && !w_d_take && (timeout_i != '0) &&
                        (TimeoutW'(r_tmo_cnt + 1'b1) == timeout_i);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (cmd_valid_i) w_state_next = A_REQ;
            A_REQ:   if (w_a_hs) w_state_next = D_WAIT;
            D_WAIT:  if (w_d_take || w_tmo_hit) w_state_next = RESP;
            RESP:    if (rsp_ready_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mask      <= '0;
            r_src_cnt   <= '0;
            r_src       <= '0;
            r_tmo_cnt   <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_timeout   <= 1'b0;
            r_stale_vld <= 1'b0;
            r_stale_src <= '0;
            r_live      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_live  <= 1'b1;
            if (r_state == IDLE && cmd_valid_i) begin
                r_write <= cmd_write_i;
                r_addr  <= cmd_addr_i;
                r_wdata <= cmd_wdata_i;
                r_mask  <= cmd_mask_i;
            end
            if (w_a_hs) begin
                r_src_cnt <= r_src_cnt + 2'd1;
                r_src     <= w_a_source;
                r_tmo_cnt <= '0;
            end else if (r_state == D_WAIT && !w_d_take) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_d_stale) begin
                r_stale_vld <= 1'b0;
            end
            if (w_d_take) begin
                r_rdata   <= (!r_write && !w_d_err) ? tl_i.d_data : 32'h0;
                r_err     <= w_d_err;
                r_timeout <= 1'b0;
            end else if (w_tmo_hit) begin
                r_rdata     <= 32'h0;
                r_err       <= 1'b1;
                r_timeout   <= 1'b1;
                r_stale_vld <= 1'b1;
                r_stale_src <= r_src;
            end
        end
    end

    always_comb begin
        w_tl_raw           = '0;
        w_tl_raw.a_valid   = (r_state == A_REQ);
        w_tl_raw.a_opcode  = !r_write ? tlul_pkg::Get :
                             (r_mask == 4'hF) ? tlul_pkg::PutFullData : tlul_pkg::PutPartialData;
        w_tl_raw.a_param   = 3'h0;
        w_tl_raw.a_size    = 2'd2;
        w_tl_raw.a_source  = w_a_source;
        w_tl_raw.a_address = 32'(r_addr) & ~32'h3;
        w_tl_raw.a_mask    = r_write ? r_mask : 4'hF;
        w_tl_raw.a_data    = r_write ? r_wdata : 32'h0;
        w_tl_raw.d_ready   = r_live;
    end

    tlul_cmd_intg_gen u_intg_gen (
        .tl_i (w_tl_raw),
        .tl_o (tl_o)
    );

    assign cmd_ready_o   = (r_state == IDLE);
    assign busy_o        = (r_state != IDLE);
    assign rsp_valid_o   = (r_state == RESP);
    assign rsp_rdata_o   = r_rdata;
    assign rsp_err_o     = r_err;
    assign rsp_timeout_o = r_timeout;

endmodule

`default_nettype wire
